// File: rtl/ofs_pkg.sv
// Shared constants, output payload type and operand-select helper for operand_fetch_stage.
// Optional feature macro used by the stage: OFS_WB_BYPASS_EN.
package ofs_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 2;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [ADDR_W-1:0] rd;
        logic              rd_we;
    } ofs_payload_t;

    // Register 0 is hardwired to zero; a bypass hit overrides the not-yet-written file value.
    function automatic logic [DATA_W-1:0] sel_operand(
        input logic [ADDR_W-1:0] src,
        input logic              byp_hit,
        input logic [DATA_W-1:0] wb_data,
        input logic [DATA_W-1:0] rf_data
    );
        logic [DATA_W-1:0] res;
        if (src == '0) begin
            res = '0;
        end else if (byp_hit) begin
            res = wb_data;
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

endpackage

// File: rtl/ofs_scoreboard.sv
// Per-register count of in-flight destination writes, with increment on issue,
// decrement on writeback and release of a flushed entry. Register 0 is never tracked.
module ofs_scoreboard
    import ofs_pkg::*;
#(
    parameter int ADDR_W = ofs_pkg::ADDR_W,
    parameter int CNT_W  = ofs_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_en_i,
    input  logic [ADDR_W-1:0]   inc_addr_i,
    input  logic                dec_en_i,
    input  logic [ADDR_W-1:0]   dec_addr_i,
    input  logic                rel_en_i,
    input  logic [ADDR_W-1:0]   rel_addr_i,
    output logic [NUM_REGS-1:0] pending_o,
    output logic [NUM_REGS-1:0] cnt_is_one_o,
    output logic [NUM_REGS-1:0] cnt_is_max_o
);

    localparam int CNT_MAX_I = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             rel_orphan;

    always_comb begin
        int nxt;
        nxt = 0;
        for (int r = 0; r < NUM_REGS; r++) begin
            nxt = int'(cnt_q[r])
                + int'(inc_en_i && (inc_addr_i == ADDR_W'(r)) && (r != 0))
                - int'(dec_en_i && (dec_addr_i == ADDR_W'(r)) && (r != 0))
                - int'(rel_en_i && (rel_addr_i == ADDR_W'(r)) && (r != 0));
            // Writebacks to idle registers (e.g. preloading the file) land here and clamp.
            if (nxt < 0) begin
                nxt = 0;
            end else if (nxt > CNT_MAX_I) begin
                nxt = CNT_MAX_I;
            end
            cnt_d[r] = CNT_W'(nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        pending_o    = '0;
        cnt_is_one_o = '0;
        cnt_is_max_o = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_o[r]    = (cnt_q[r] != '0);
            cnt_is_one_o[r] = (cnt_q[r] == CNT_W'(1));
            cnt_is_max_o[r] = (cnt_q[r] == {CNT_W{1'b1}});
        end
    end

    // A flushed entry must always own a pending count; releasing an idle register is a bug.
    assign rel_orphan = rel_en_i && (rel_addr_i != '0) && (cnt_q[rel_addr_i] == '0);

    assert property (@(posedge clk) disable iff (!rst_n) !rel_orphan)
        else $error("ofs_scoreboard: flush release of register with no pending write");

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: register-file read, RAW scoreboard stall, ID/EX output register.
// Define OFS_WB_BYPASS_EN to forward the same-cycle writeback value into the operands.
module operand_fetch_stage
    import ofs_pkg::*;
#(
    parameter int DATA_W = ofs_pkg::DATA_W,
    parameter int ADDR_W = ofs_pkg::ADDR_W,
    parameter int CNT_W  = ofs_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic              in_rs_used,
    input  logic              in_rt_used,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_we,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_rd_we
);

    logic                byp_a;
    logic                byp_b;
    logic                hazard_a;
    logic                hazard_b;
    logic                struct_stall;
    logic                accept;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] cnt_is_one;
    logic [NUM_REGS-1:0] cnt_is_max;

    logic                out_valid_q;
    logic                out_valid_d;
    ofs_payload_t        out_q;
    ofs_payload_t        out_d;

    assign rf_raddr1 = in_rs;
    assign rf_raddr2 = in_rt;

`ifdef OFS_WB_BYPASS_EN
    assign byp_a = wb_en && (wb_addr == in_rs) && (in_rs != '0);
    assign byp_b = wb_en && (wb_addr == in_rt) && (in_rt != '0);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign op_a = sel_operand(in_rs, byp_a, wb_data, rf_rdata1);
    assign op_b = sel_operand(in_rt, byp_b, wb_data, rf_rdata2);

    // The last outstanding writer retiring this cycle is covered by the bypass.
    assign hazard_a = in_rs_used && (in_rs != '0) && pending[in_rs]
                    && !(byp_a && cnt_is_one[in_rs]);
    assign hazard_b = in_rt_used && (in_rt != '0) && pending[in_rt]
                    && !(byp_b && cnt_is_one[in_rt]);

    // A full counter can still take a new writer when one of its writes retires now.
    assign struct_stall = in_rd_we && (in_rd != '0) && cnt_is_max[in_rd]
                        && !(wb_en && (wb_addr == in_rd));

    assign in_ready = !flush && (!out_valid_q || out_ready)
                    && !hazard_a && !hazard_b && !struct_stall;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d.op_a  = op_a;
            out_d.op_b  = op_b;
            out_d.rd    = in_rd;
            out_d.rd_we = in_rd_we;
        end else if (flush) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    ofs_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_en_i     (accept && in_rd_we && (in_rd != '0)),
        .inc_addr_i   (in_rd),
        .dec_en_i     (wb_en && (wb_addr != '0)),
        .dec_addr_i   (wb_addr),
        .rel_en_i     (flush && out_valid_q && out_q.rd_we && (out_q.rd != '0)),
        .rel_addr_i   (out_q.rd),
        .pending_o    (pending),
        .cnt_is_one_o (cnt_is_one),
        .cnt_is_max_o (cnt_is_max)
    );

    assign out_valid = out_valid_q;
    assign out_op_a  = out_q.op_a;
    assign out_op_b  = out_q.op_b;
    assign out_rd    = out_q.rd;
    assign out_rd_we = out_q.rd_we;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a behavioural register file on the read ports.
// Expectations follow OFS_WB_BYPASS_EN when the bench is built with it.
module tb_operand_fetch_stage;

    localparam int DW = 32;
    localparam int AW = 5;

`ifdef OFS_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [AW-1:0] in_rs, in_rt, in_rd;
    logic          in_rs_used, in_rt_used, in_rd_we;
    logic [AW-1:0] rf_raddr1, rf_raddr2;
    logic [DW-1:0] rf_rdata1, rf_rdata2;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_op_a, out_op_b;
    logic [AW-1:0] out_rd;
    logic          out_rd_we;

    logic [DW-1:0] regs [32];
    logic          force_ones;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Register file model: combinational read, write committed on the clock edge.
    always @(posedge clk) begin
        if (wb_en) regs[wb_addr] <= wb_data;
    end
    assign rf_rdata1 = force_ones ? '1 : regs[rf_raddr1];
    assign rf_rdata2 = force_ones ? '1 : regs[rf_raddr2];

    operand_fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rs_used (in_rs_used),
        .in_rt_used (in_rt_used),
        .in_rd      (in_rd),
        .in_rd_we   (in_rd_we),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op_a   (out_op_a),
        .out_op_b   (out_op_b),
        .out_rd     (out_rd),
        .out_rd_we  (out_rd_we)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [AW-1:0] rs, input logic rs_u,
                             input logic [AW-1:0] rt, input logic rt_u,
                             input logic [AW-1:0] rd, input logic rd_we);
        in_rs = rs; in_rs_used = rs_u;
        in_rt = rt; in_rt_used = rt_u;
        in_rd = rd; in_rd_we   = rd_we;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; force_ones = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0);

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op_a", out_op_a, 0);
        chk("rst_op_b", out_op_b, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_rd_we", out_rd_we, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Preload r8/r13, then read both
        wb_en = 1'b1; wb_addr = 8; wb_data = 294; step();
        wb_addr = 13; wb_data = 194; step();
        wb_en = 1'b0;
        in_valid = 1'b1; set_instr(8, 1, 13, 1, 0, 0);
        #1;
        chk("raddr1", rf_raddr1, 8);
        chk("raddr2", rf_raddr2, 13);
        chk("read_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("read_valid", out_valid, 1);
        chk("read_op_a", out_op_a, 294);
        chk("read_op_b", out_op_b, 194);

        // RAW hazard on r3
        in_valid = 1'b1; set_instr(0, 0, 0, 0, 3, 1);
        #1 chk("rd3_issue", in_ready, 1);
        step();
        set_instr(3, 1, 0, 0, 0, 0);
        #1 chk("raw_stall0", in_ready, 0);
        step();
        #1 chk("raw_stall1", in_ready, 0);
        wb_en = 1'b1; wb_addr = 3; wb_data = 48;
        #1 chk("raw_wb_cycle", in_ready, BYP);
        step();
        wb_en = 1'b0;
`ifndef OFS_WB_BYPASS_EN
        #1 chk("raw_after_wb", in_ready, 1);
        step();
`endif
        in_valid = 1'b0;
        chk("raw_valid", out_valid, 1);
        chk("raw_op_a", out_op_a, 48);

        // Register 0 always reads zero
        in_valid = 1'b1; set_instr(0, 1, 0, 1, 0, 0); force_ones = 1'b1;
        #1 chk("r0_ready", in_ready, 1);
        step();
        in_valid = 1'b0; force_ones = 1'b0;
        chk("r0_op_a", out_op_a, 0);
        chk("r0_op_b", out_op_b, 0);

        // Scoreboard saturation on r10
        in_valid = 1'b1; set_instr(0, 0, 0, 0, 10, 1);
        for (int i = 0; i < 3; i++) begin
            #1 chk("r10_issue", in_ready, 1);
            step();
        end
        #1 chk("r10_full", in_ready, 0);
        step();
        #1 chk("r10_full_hold", in_ready, 0);
        wb_en = 1'b1; wb_addr = 10; wb_data = 77;
        #1 chk("r10_wb_relax", in_ready, 1);
        step();
        wb_en = 1'b0;
        chk("r10_out_rd", out_rd, 10);
        chk("r10_out_rd_we", out_rd_we, 1);
        #1 chk("r10_still_full", in_ready, 0);
        in_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 10;
        wb_data = 100; step();
        wb_data = 200; step();
        wb_data = 300; step();
        wb_en = 1'b0;

        // Flush releases the held entry's pending count
        out_ready = 1'b0;
        in_valid = 1'b1; set_instr(0, 0, 0, 0, 10, 1);
        #1 chk("flush_setup", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("flush_held_valid", out_valid, 1);
        chk("flush_held_rd", out_rd, 10);
        flush = 1'b1; wb_en = 1'b1; wb_addr = 10; wb_data = 555;
        in_valid = 1'b1; set_instr(0, 0, 0, 0, 0, 0);
        #1 chk("flush_cycle_ready", in_ready, 0);
        step();
        flush = 1'b0; wb_en = 1'b0;
        chk("flush_clears_valid", out_valid, 0);
        set_instr(10, 1, 0, 0, 0, 0);
        #1 chk("flush_released", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("flush_next_op_a", out_op_a, 555);

        // Downstream backpressure holds the output register
        in_valid = 1'b1; set_instr(8, 1, 13, 1, 5, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_op_a", out_op_a, 555);
            step();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_new_op_a", out_op_a, 294);
        chk("bp_new_op_b", out_op_b, 194);
        chk("bp_new_rd", out_rd, 5);
        chk("bp_new_rd_we", out_rd_we, 0);

        // Asynchronous reset in the middle of a stall
        in_valid = 1'b1; set_instr(0, 0, 0, 0, 3, 1);
        step();
        set_instr(3, 1, 0, 0, 0, 0);
        #1 chk("pre_reset_stall", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 0);
        chk("async_reset_rd", out_rd, 0);
        step();
        rst_n = 1'b1;
        #1 chk("post_reset_sb_clear", in_ready, 1);
        in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
